// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with an integrated ID/EX register.
// Extracts register fields, selects operands, detects RAW/load-use hazards,
// resolves branches in ID and registers a bubble-capable bundle for EXE.
// Optional build macro ID_PERF_CNT_EN adds stall/bubble performance counters.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 5,
  parameter int FWD_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              mem_w_in,
  input  logic              mem_r_in,
  input  logic              wb_in,
  input  logic              is_imm,
  input  logic              st_or_bne,
  input  logic              is_br,
  input  logic              br_type,
  input  logic              is_jmp,
  input  logic [4:0]        Exe_Dest,
  input  logic [4:0]        Mem_Dest,
  input  logic              Exe_WB_en,
  input  logic              Mem_WB_en,
  input  logic              Exe_MEM_R_en,
  input  logic              freeze,
  input  logic              flush,
  output logic [4:0]        src1_to_reg,
  output logic [4:0]        src2_to_reg,
  output logic              hazard_Detected,
  output logic              Br_taken,
  output logic              ex_valid,
  output logic              ex_mem_w,
  output logic              ex_mem_r,
  output logic              ex_wb,
  output logic [CMD_W-1:0]  ex_cmd,
  output logic [4:0]        ex_dest,
  output logic [4:0]        ex_src1,
  output logic [4:0]        ex_src2,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_reg2
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam bit FWD = (FWD_EN != 0);

  logic [5:0]        unused_opcode;
  logic [4:0]        f_dest;
  logic [4:0]        f_src1;
  logic [4:0]        f_src2;
  logic [15:0]       f_imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] val2;
  logic              src1_used;
  logic              src2_used;
  logic              exe_match;
  logic              mem_match;
  logic              raw_hazard;
  logic              load_use;
  logic              hazard;
  logic              br_cond;
  logic              bubble;

  // The opcode is consumed by the control unit, not here.
  assign unused_opcode = instr[31:26];

  // Field extraction and register-file read addresses.
  always_comb begin
    f_dest = instr[25:21];
    f_src1 = instr[20:16];
    f_imm  = instr[15:0];
    // Stores and bne read the dest field as their second source.
    f_src2 = st_or_bne ? instr[25:21] : instr[15:11];
    src1_to_reg = f_src1;
    src2_to_reg = (is_imm & ~st_or_bne) ? 5'd0 : f_src2;
  end

  // Operand selection; the immediate is sign-extended to the data width.
  always_comb begin
    imm_ext = {{(DATA_W-16){f_imm[15]}}, f_imm};
    val2    = is_imm ? imm_ext : reg2;
  end

  // Hazard detection. Register 0 is never a real dependency.
  always_comb begin
    src1_used  = (f_src1 != 5'd0);
    src2_used  = (~is_imm | st_or_bne) & (f_src2 != 5'd0);
    exe_match  = Exe_WB_en & ((src1_used & (f_src1 == Exe_Dest)) |
                              (src2_used & (f_src2 == Exe_Dest)));
    mem_match  = Mem_WB_en & ((src1_used & (f_src1 == Mem_Dest)) |
                              (src2_used & (f_src2 == Mem_Dest)));
    raw_hazard = exe_match | mem_match;
    load_use   = exe_match & Exe_MEM_R_en;
    // Branches compare operands in ID, where nothing is forwarded, so they
    // always need the full RAW check even when EXE forwarding exists.
    if (FWD && !is_br) begin
      hazard = instr_valid & load_use;
    end else begin
      hazard = instr_valid & raw_hazard;
    end
    hazard_Detected = hazard;
  end

  // Branch resolution; suppressed whenever the operands may be stale or ID is squashed/held.
  always_comb begin
    br_cond  = br_type ? (reg1 != reg2) : (reg1 == '0);
    Br_taken = instr_valid & ~hazard & ~flush & ~freeze &
               (is_jmp | (is_br & br_cond));
  end

  assign bubble = flush | hazard;

  // ID/EX register: freeze holds, flush/hazard load a bubble, else load the bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_mem_w <= 1'b0;
      ex_mem_r <= 1'b0;
      ex_wb    <= 1'b0;
      ex_cmd   <= '0;
      ex_dest  <= '0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_val1  <= '0;
      ex_val2  <= '0;
      ex_reg2  <= '0;
    end else if (freeze) begin
      ex_valid <= ex_valid;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_mem_w <= 1'b0;
      ex_mem_r <= 1'b0;
      ex_wb    <= 1'b0;
      ex_cmd   <= '0;
      ex_dest  <= '0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_val1  <= '0;
      ex_val2  <= '0;
      ex_reg2  <= '0;
    end else begin
      ex_valid <= instr_valid;
      ex_mem_w <= mem_w_in & instr_valid;
      ex_mem_r <= mem_r_in & instr_valid;
      ex_wb    <= wb_in & instr_valid;
      ex_cmd   <= exe_cmd_in;
      ex_dest  <= f_dest;
      ex_src1  <= f_src1;
      // The masked address keeps the forwarding unit from matching an unused field.
      ex_src2  <= src2_to_reg;
      ex_val1  <= reg1;
      ex_val2  <= val2;
      ex_reg2  <= reg2;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Performance counters: IF stall cycles and bubbles injected into EXE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!freeze) begin
      if (hazard) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bubble) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: two instances (no forwarding / load-use
// forwarding) share one stimulus stream; directed vectors push hand-computed
// expectations and a monitor process checks them.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] reg1, reg2;
  logic [4:0]  exe_cmd_in;
  logic        mem_w_in, mem_r_in, wb_in, is_imm, st_or_bne, is_br, br_type, is_jmp;
  logic [4:0]  Exe_Dest, Mem_Dest;
  logic        Exe_WB_en, Mem_WB_en, Exe_MEM_R_en, freeze, flush;

  logic [4:0]  s1r_0, s2r_0, s1r_1, s2r_1;
  logic        haz_0, br_0, haz_1, br_1;
  logic        ex_valid_0, ex_mem_w_0, ex_mem_r_0, ex_wb_0;
  logic        ex_valid_1, ex_mem_w_1, ex_mem_r_1, ex_wb_1;
  logic [4:0]  ex_cmd_0, ex_dest_0, ex_src1_0, ex_src2_0;
  logic [4:0]  ex_cmd_1, ex_dest_1, ex_src1_1, ex_src2_1;
  logic [31:0] ex_val1_0, ex_val2_0, ex_reg2_0, ex_val1_1, ex_val2_1, ex_reg2_1;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_0, bubble_cnt_0, stall_cnt_1, bubble_cnt_1;
`endif

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .CMD_W(5), .FWD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .reg1(reg1), .reg2(reg2), .exe_cmd_in(exe_cmd_in),
    .mem_w_in(mem_w_in), .mem_r_in(mem_r_in), .wb_in(wb_in), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .is_br(is_br), .br_type(br_type), .is_jmp(is_jmp),
    .Exe_Dest(Exe_Dest), .Mem_Dest(Mem_Dest), .Exe_WB_en(Exe_WB_en),
    .Mem_WB_en(Mem_WB_en), .Exe_MEM_R_en(Exe_MEM_R_en), .freeze(freeze), .flush(flush),
    .src1_to_reg(s1r_0), .src2_to_reg(s2r_0), .hazard_Detected(haz_0), .Br_taken(br_0),
    .ex_valid(ex_valid_0), .ex_mem_w(ex_mem_w_0), .ex_mem_r(ex_mem_r_0), .ex_wb(ex_wb_0),
    .ex_cmd(ex_cmd_0), .ex_dest(ex_dest_0), .ex_src1(ex_src1_0), .ex_src2(ex_src2_0),
    .ex_val1(ex_val1_0), .ex_val2(ex_val2_0), .ex_reg2(ex_reg2_0)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt_0), .bubble_cnt(bubble_cnt_0)
`endif
  );

  id_stage_pipe #(.DATA_W(32), .CMD_W(5), .FWD_EN(1)) dut1 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .reg1(reg1), .reg2(reg2), .exe_cmd_in(exe_cmd_in),
    .mem_w_in(mem_w_in), .mem_r_in(mem_r_in), .wb_in(wb_in), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .is_br(is_br), .br_type(br_type), .is_jmp(is_jmp),
    .Exe_Dest(Exe_Dest), .Mem_Dest(Mem_Dest), .Exe_WB_en(Exe_WB_en),
    .Mem_WB_en(Mem_WB_en), .Exe_MEM_R_en(Exe_MEM_R_en), .freeze(freeze), .flush(flush),
    .src1_to_reg(s1r_1), .src2_to_reg(s2r_1), .hazard_Detected(haz_1), .Br_taken(br_1),
    .ex_valid(ex_valid_1), .ex_mem_w(ex_mem_w_1), .ex_mem_r(ex_mem_r_1), .ex_wb(ex_wb_1),
    .ex_cmd(ex_cmd_1), .ex_dest(ex_dest_1), .ex_src1(ex_src1_1), .ex_src2(ex_src2_1),
    .ex_val1(ex_val1_1), .ex_val2(ex_val2_1), .ex_reg2(ex_reg2_1)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt_1), .bubble_cnt(bubble_cnt_1)
`endif
  );

  typedef struct packed {
    logic        valid, mem_w, mem_r, wb;
    logic [4:0]  cmd, dest, src1, src2;
    logic [31:0] val1, val2, reg2;
  } ex_t;

  typedef struct {
    logic       haz0, haz1, br0, br1;
    logic [4:0] s1r, s2r;
    ex_t        ex0, ex1;
  } item_t;

  localparam int LOAD = 0;
  localparam int BUB  = 1;
  localparam int HOLD = 2;

  item_t q[$];
  ex_t   prev0, prev1;
  int    total = 0;
  int    bad   = 0;

  function automatic ex_t got0();
    ex_t e;
    e = {ex_valid_0, ex_mem_w_0, ex_mem_r_0, ex_wb_0, ex_cmd_0, ex_dest_0,
         ex_src1_0, ex_src2_0, ex_val1_0, ex_val2_0, ex_reg2_0};
    return e;
  endfunction

  function automatic ex_t got1();
    ex_t e;
    e = {ex_valid_1, ex_mem_w_1, ex_mem_r_1, ex_wb_1, ex_cmd_1, ex_dest_1,
         ex_src1_1, ex_src2_1, ex_val1_1, ex_val2_1, ex_reg2_1};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected ID/EX content after the edge, for the given action.
  function automatic ex_t build(int act, ex_t prev, logic [4:0] s2r, logic [31:0] v2);
    ex_t e;
    e = '0;
    if (act == HOLD) begin
      e = prev;
    end else if (act == LOAD) begin
      e.valid = instr_valid;
      e.mem_w = mem_w_in & instr_valid;
      e.mem_r = mem_r_in & instr_valid;
      e.wb    = wb_in & instr_valid;
      e.cmd   = exe_cmd_in;
      e.dest  = instr[25:21];
      e.src1  = instr[20:16];
      e.src2  = s2r;
      e.val1  = reg1;
      e.val2  = v2;
      e.reg2  = reg2;
    end
    return e;
  endfunction

  task automatic push(input logic h0, input logic h1, input logic b0, input logic b1,
                      input logic [4:0] s2r, input int a0, input int a1,
                      input logic [31:0] v2);
    item_t it;
    it.haz0 = h0; it.haz1 = h1; it.br0 = b0; it.br1 = b1;
    it.s1r  = instr[20:16];
    it.s2r  = s2r;
    it.ex0  = build(a0, prev0, s2r, v2);
    it.ex1  = build(a1, prev1, s2r, v2);
    prev0   = it.ex0;
    prev1   = it.ex1;
    q.push_back(it);
  endtask

  task automatic defaults();
    instr = '0; instr_valid = 1'b1; reg1 = '0; reg2 = '0; exe_cmd_in = '0;
    mem_w_in = 0; mem_r_in = 0; wb_in = 0; is_imm = 0; st_or_bne = 0;
    is_br = 0; br_type = 0; is_jmp = 0; Exe_Dest = '0; Mem_Dest = '0;
    Exe_WB_en = 0; Mem_WB_en = 0; Exe_MEM_R_en = 0; freeze = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    defaults();
  endtask

  // Monitor: combinational outputs mid-cycle, registered bundle just after the edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("hazard0", 128'(haz_0), 128'(it.haz0));
        chk("hazard1", 128'(haz_1), 128'(it.haz1));
        chk("br0", 128'(br_0), 128'(it.br0));
        chk("br1", 128'(br_1), 128'(it.br1));
        chk("src1_to_reg", 128'(s1r_0), 128'(it.s1r));
        chk("src2_to_reg", 128'(s2r_0), 128'(it.s2r));
        chk("src2_to_reg1", 128'(s2r_1), 128'(it.s2r));
        @(posedge clk);
        #1;
        chk("ex0", 128'(got0()), 128'(it.ex0));
        chk("ex1", 128'(got1()), 128'(it.ex1));
      end
    end
  end

  initial begin
    int waits;
    rst = 1'b1;
    defaults();
    instr_valid = 1'b0;
    prev0 = '0;
    prev1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex0", 128'(got0()), 128'd0);
    chk("reset_ex1", 128'(got1()), 128'd0);
    #1;
    rst = 1'b0;

    // Immediate decode with sign extension
    cyc(); instr = {6'd1, 5'd3, 5'd1, 16'hFFF0}; reg1 = 32'h11; reg2 = 32'h22;
    exe_cmd_in = 5'd4; wb_in = 1; is_imm = 1;
    push(0, 0, 0, 0, 5'd0, LOAD, LOAD, 32'hFFFF_FFF0);
    // RAW on src1 vs EXE (non-load): stalls only without forwarding
    cyc(); instr = {6'd0, 5'd2, 5'd5, 5'd6, 11'd0}; reg1 = 32'h55; reg2 = 32'h66;
    exe_cmd_in = 5'd1; wb_in = 1; Exe_Dest = 5'd5; Exe_WB_en = 1;
    push(1, 0, 0, 0, 5'd6, BUB, LOAD, 32'h66);
    // Same with src1 = r0: never a hazard
    cyc(); instr = {6'd0, 5'd2, 5'd0, 5'd6, 11'd0}; reg2 = 32'h66;
    exe_cmd_in = 5'd1; wb_in = 1; Exe_Dest = 5'd5; Exe_WB_en = 1;
    push(0, 0, 0, 0, 5'd6, LOAD, LOAD, 32'h66);
    // src2 vs EXE, producer not a load
    cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd7, 11'd0}; reg1 = 32'h1; reg2 = 32'h77;
    exe_cmd_in = 5'd2; mem_r_in = 1; wb_in = 1; Exe_Dest = 5'd7; Exe_WB_en = 1;
    push(1, 0, 0, 0, 5'd7, BUB, LOAD, 32'h77);
    // Load-use: both stall
    cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd7, 11'd0}; reg1 = 32'h1; reg2 = 32'h77;
    exe_cmd_in = 5'd2; mem_r_in = 1; wb_in = 1; Exe_Dest = 5'd7; Exe_WB_en = 1; Exe_MEM_R_en = 1;
    push(1, 1, 0, 0, 5'd7, BUB, BUB, 32'h0);
    // bne equal: not taken
    cyc(); instr = {6'd5, 5'd4, 5'd3, 16'h0008}; is_br = 1; br_type = 1; st_or_bne = 1;
    is_imm = 1; reg1 = 32'd4; reg2 = 32'd4;
    push(0, 0, 0, 0, 5'd4, LOAD, LOAD, 32'h8);
    // bne unequal: taken
    cyc(); instr = {6'd5, 5'd4, 5'd3, 16'h0008}; is_br = 1; br_type = 1; st_or_bne = 1;
    is_imm = 1; reg1 = 32'd4; reg2 = 32'd5;
    push(0, 0, 1, 1, 5'd4, LOAD, LOAD, 32'h8);
    // bne with MEM producer on src1: branch stalls even with forwarding
    cyc(); instr = {6'd5, 5'd4, 5'd3, 16'h0008}; is_br = 1; br_type = 1; st_or_bne = 1;
    is_imm = 1; reg1 = 32'd4; reg2 = 32'd5; Mem_Dest = 5'd3; Mem_WB_en = 1;
    push(1, 1, 0, 0, 5'd4, BUB, BUB, 32'h0);
    // Non-branch MEM match: forwarding covers it
    cyc(); instr = {6'd0, 5'd2, 5'd3, 5'd6, 11'd0}; reg1 = 32'hA; reg2 = 32'hB;
    wb_in = 1; Mem_Dest = 5'd3; Mem_WB_en = 1;
    push(1, 0, 0, 0, 5'd6, BUB, LOAD, 32'hB);
    // beqz taken, negative offset
    cyc(); instr = {6'd4, 5'd0, 5'd9, 16'hFFFC}; is_br = 1; is_imm = 1; reg1 = 32'd0; reg2 = 32'h99;
    push(0, 0, 1, 1, 5'd0, LOAD, LOAD, 32'hFFFF_FFFC);
    // beqz not taken
    cyc(); instr = {6'd4, 5'd0, 5'd9, 16'hFFFC}; is_br = 1; is_imm = 1; reg1 = 32'd7; reg2 = 32'h99;
    push(0, 0, 0, 0, 5'd0, LOAD, LOAD, 32'hFFFF_FFFC);
    // Jump
    cyc(); instr = {6'd2, 26'd0}; is_jmp = 1; reg2 = 32'h1234;
    push(0, 0, 1, 1, 5'd0, LOAD, LOAD, 32'h1234);
    // Invalid slot: no hazard, no jump, enables cleared
    cyc(); instr = {6'd0, 5'd2, 5'd5, 5'd0, 11'd0}; instr_valid = 0; is_jmp = 1;
    mem_w_in = 1; wb_in = 1; reg1 = 32'h3; reg2 = 32'h4;
    Exe_Dest = 5'd5; Exe_WB_en = 1; Exe_MEM_R_en = 1;
    push(0, 0, 0, 0, 5'd0, LOAD, LOAD, 32'h4);
    // Known bundle, then freeze+flush twice: held
    cyc(); instr = {6'd0, 5'd10, 5'd11, 5'd12, 11'd0}; reg1 = 32'hA1; reg2 = 32'hB2;
    exe_cmd_in = 5'd7; wb_in = 1; mem_w_in = 1;
    push(0, 0, 0, 0, 5'd12, LOAD, LOAD, 32'hB2);
    for (int i = 0; i < 2; i++) begin
      cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0}; reg1 = 32'hDEAD; reg2 = 32'hBEEF;
      is_jmp = 1; freeze = 1; flush = 1; wb_in = 1;
      push(0, 0, 0, 0, 5'd3, HOLD, HOLD, 32'h0);
    end
    // Freeze with a load-use hazard: hold, hazard still visible
    cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0}; freeze = 1;
    Exe_Dest = 5'd2; Exe_WB_en = 1; Exe_MEM_R_en = 1;
    push(1, 1, 0, 0, 5'd3, HOLD, HOLD, 32'h0);
    // Flush alone: bubble, jump suppressed
    cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0}; is_jmp = 1; flush = 1; wb_in = 1;
    push(0, 0, 0, 0, 5'd3, BUB, BUB, 32'h0);
    // Load again, then reset mid-freeze
    cyc(); instr = {6'd0, 5'd10, 5'd11, 5'd12, 11'd0}; reg1 = 32'hA1; reg2 = 32'hB2;
    exe_cmd_in = 5'd7; wb_in = 1;
    push(0, 0, 0, 0, 5'd12, LOAD, LOAD, 32'hB2);
    cyc(); instr = {6'd0, 5'd10, 5'd11, 5'd12, 11'd0}; freeze = 1;
    push(0, 0, 0, 0, 5'd12, HOLD, HOLD, 32'h0);
    cyc(); freeze = 1; instr_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_async_ex0", 128'(got0()), 128'd0);
    chk("rst_async_ex1", 128'(got1()), 128'd0);
    @(posedge clk);
    #1;
    chk("rst_held_ex0", 128'(got0()), 128'd0);
    #1;
    defaults();
    instr_valid = 0;
    rst = 1'b0;
    prev0 = '0;
    prev1 = '0;

    // Three load-use stall cycles then one flush
    for (int i = 0; i < 3; i++) begin
      cyc(); instr = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0};
      Exe_Dest = 5'd2; Exe_WB_en = 1; Exe_MEM_R_en = 1;
      push(1, 1, 0, 0, 5'd3, BUB, BUB, 32'h0);
    end
    cyc(); flush = 1;
    push(0, 0, 0, 0, 5'd0, BUB, BUB, 32'h0);
    cyc(); instr_valid = 0;
    push(0, 0, 0, 0, 5'd0, LOAD, LOAD, 32'h0);
`ifdef ID_PERF_CNT_EN
    #1;
    chk("stall_cnt0", 128'(stall_cnt_0), 128'd3);
    chk("bubble_cnt0", 128'(bubble_cnt_0), 128'd4);
    chk("stall_cnt1", 128'(stall_cnt_1), 128'd3);
    chk("bubble_cnt1", 128'(bubble_cnt_1), 128'd4);
`endif

    waits = 0;
    while (q.size() > 0 && waits < 20) begin
      @(posedge clk);
      waits++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
